// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: takes PCs from the incrementer, reads instruction memory
// over req/ack, and presents instruction + PC to decode under valid/ready.
module inst_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] Pc_In,
    input  logic              Pc_Valid,
    output logic              Mem_Req,
    output logic [ADDR_W-1:0] Mem_Addr,
    input  logic              Mem_Ack,
    input  logic [DATA_W-1:0] Mem_Rdata,
    output logic [DATA_W-1:0] Inst_Out,
    output logic [ADDR_W-1:0] Inst_Pc,
    output logic              Inst_Valid,
    input  logic              Inst_Ready,
    output logic              Fetch_Err,
    output logic              Pc_Overrun
);

    localparam int               CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_inc;
    logic [ADDR_W-1:0] pend_pc;
    logic              pend_full;
    logic [ADDR_W-1:0] next_pc;

    // A buffered PC is older than anything on Pc_In, so it is launched first.
    assign next_pc      = pend_full ? pend_pc : Pc_In;
    assign wait_cnt_inc = wait_cnt + 1'b1;

    // NOTE: every register here is updated with <= so all branches see pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            Mem_Req    <= 1'b0;
            Mem_Addr   <= '0;
            Inst_Out   <= '0;
            Inst_Pc    <= '0;
            Inst_Valid <= 1'b0;
            Fetch_Err  <= 1'b0;
            Pc_Overrun <= 1'b0;
            wait_cnt   <= '0;
            pend_pc    <= '0;
            pend_full  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pend_full || Pc_Valid) begin
                        if (next_pc[1:0] == 2'b00) begin
                            Mem_Addr <= next_pc;
                            Mem_Req  <= 1'b1;
                            wait_cnt <= '0;
                            state    <= REQ;
                        end else begin
                            Inst_Out   <= NOP_WORD;
                            Inst_Pc    <= next_pc;
                            Fetch_Err  <= 1'b1;
                            Inst_Valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end
                    // Draining the buffer while a new PC arrives refills it; not an overrun.
                    if (pend_full) begin
                        pend_pc   <= Pc_In;
                        pend_full <= Pc_Valid;
                    end
                end

                REQ: begin
                    wait_cnt <= wait_cnt_inc;
                    if (Mem_Ack) begin
                        Inst_Out   <= Mem_Rdata;
                        Inst_Pc    <= Mem_Addr;
                        Fetch_Err  <= 1'b0;
                        Inst_Valid <= 1'b1;
                        Mem_Req    <= 1'b0;
                        state      <= HOLD;
                    end else if (wait_cnt_inc == TIMEOUT_CNT) begin
                        Inst_Out   <= NOP_WORD;
                        Inst_Pc    <= Mem_Addr;
                        Fetch_Err  <= 1'b1;
                        Inst_Valid <= 1'b1;
                        Mem_Req    <= 1'b0;
                        state      <= HOLD;
                    end
                end

                HOLD: begin
                    if (Inst_Ready) begin
                        Inst_Valid <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    Mem_Req    <= 1'b0;
                    Inst_Valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase

            // While busy, every new PC lands in the buffer; newest wins.
            if (state != IDLE && Pc_Valid) begin
                pend_pc   <= Pc_In;
                pend_full <= 1'b1;
                if (pend_full) begin
                    Pc_Overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: reset, cadence, backpressure, misalignment,
// timeout, ack-on-last-cycle and mid-fetch reset.
module tb_inst_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] Pc_In;
    logic        Pc_Valid;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic        Mem_Ack;
    logic [31:0] Mem_Rdata;
    logic [31:0] Inst_Out;
    logic [31:0] Inst_Pc;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic        Fetch_Err;
    logic        Pc_Overrun;

    int n_checks = 0;
    int n_fail   = 0;

    inst_fetch_unit dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Pc_In      (Pc_In),
        .Pc_Valid   (Pc_Valid),
        .Mem_Req    (Mem_Req),
        .Mem_Addr   (Mem_Addr),
        .Mem_Ack    (Mem_Ack),
        .Mem_Rdata  (Mem_Rdata),
        .Inst_Out   (Inst_Out),
        .Inst_Pc    (Inst_Pc),
        .Inst_Valid (Inst_Valid),
        .Inst_Ready (Inst_Ready),
        .Fetch_Err  (Fetch_Err),
        .Pc_Overrun (Pc_Overrun)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled and inputs driven here.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] pc;

        Rst = 1'b1; Pc_In = '0; Pc_Valid = 1'b0;
        Mem_Ack = 1'b0; Mem_Rdata = '0; Inst_Ready = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_req",     Mem_Req,    0);
        check("rst_addr",    Mem_Addr,   0);
        check("rst_valid",   Inst_Valid, 0);
        check("rst_inst",    Inst_Out,   0);
        check("rst_pc",      Inst_Pc,    0);
        check("rst_err",     Fetch_Err,  0);
        check("rst_overrun", Pc_Overrun, 0);
        Rst = 1'b0;
        tick();

        // Single zero-wait fetch
        Pc_In = 32'h40; Pc_Valid = 1'b1;
        tick();
        Pc_Valid = 1'b0;
        check("single_req",    Mem_Req,    1);
        check("single_addr",   Mem_Addr,   32'h40);
        check("single_nvalid", Inst_Valid, 0);
        Mem_Ack = 1'b1; Mem_Rdata = 32'h2008_0005;
        tick();
        Mem_Ack = 1'b0;
        check("single_valid", Inst_Valid, 1);
        check("single_inst",  Inst_Out,   32'h2008_0005);
        check("single_pc",    Inst_Pc,    32'h40);
        check("single_err",   Fetch_Err,  0);
        check("single_reqlo", Mem_Req,    0);
        Inst_Ready = 1'b1;
        tick();
        check("single_consumed", Inst_Valid, 0);

        // Incrementer cadence, 1-wait memory, ready tied high
        for (int i = 0; i < 4; i++) begin
            pc = 32'(i * 4);
            Pc_In = pc; Pc_Valid = 1'b1;
            tick();
            Pc_Valid = 1'b0;
            check("cad_req",  Mem_Req,  1);
            check("cad_addr", Mem_Addr, pc);
            tick();
            Mem_Ack = 1'b1; Mem_Rdata = 32'h1000_0000 | pc;
            tick();
            Mem_Ack = 1'b0;
            check("cad_valid", Inst_Valid, 1);
            check("cad_pc",    Inst_Pc,    pc);
            check("cad_inst",  Inst_Out,   32'h1000_0000 | pc);
            tick();
        end
        check("cad_overrun", Pc_Overrun, 0);

        // Decode backpressure: 0x14 is overwritten by 0x18
        Inst_Ready = 1'b0;
        Pc_In = 32'h10; Pc_Valid = 1'b1;
        tick();
        Pc_Valid = 1'b0; Mem_Ack = 1'b1; Mem_Rdata = 32'hAAAA_0010;
        tick();
        Mem_Ack = 1'b0;
        check("bp_pc0", Inst_Pc, 32'h10);
        Pc_In = 32'h14; Pc_Valid = 1'b1;
        tick();
        Pc_Valid = 1'b0;
        check("bp_no_overrun_yet", Pc_Overrun, 0);
        tick(); tick(); tick();
        Pc_In = 32'h18; Pc_Valid = 1'b1;
        tick();
        Pc_Valid = 1'b0;
        check("bp_overrun", Pc_Overrun, 1);
        tick(); tick(); tick();
        check("bp_hold_valid", Inst_Valid, 1);
        check("bp_hold_pc",    Inst_Pc,    32'h10);
        check("bp_hold_inst",  Inst_Out,   32'hAAAA_0010);
        check("bp_hold_noreq", Mem_Req,    0);
        Inst_Ready = 1'b1;
        tick();
        check("bp_released", Inst_Valid, 0);
        tick();
        check("bp_req2",  Mem_Req,  1);
        check("bp_addr2", Mem_Addr, 32'h18);
        Mem_Ack = 1'b1; Mem_Rdata = 32'hAAAA_0018;
        tick();
        Mem_Ack = 1'b0;
        check("bp_pc2",   Inst_Pc,  32'h18);
        check("bp_inst2", Inst_Out, 32'hAAAA_0018);
        tick();

        // Misaligned PC
        Inst_Ready = 1'b0;
        Pc_In = 32'h42; Pc_Valid = 1'b1;
        tick();
        Pc_Valid = 1'b0;
        check("mis_noreq", Mem_Req,    0);
        check("mis_valid", Inst_Valid, 1);
        check("mis_inst",  Inst_Out,   0);
        check("mis_err",   Fetch_Err,  1);
        check("mis_pc",    Inst_Pc,    32'h42);
        Inst_Ready = 1'b1;
        tick();

        // Timeout: no ack ever
        Pc_In = 32'h80; Pc_Valid = 1'b1;
        tick();
        Pc_Valid = 1'b0;
        n = 0;
        while (Mem_Req && n < 40) begin
            n++;
            tick();
        end
        check("to_req_cycles", n,          16);
        check("to_valid",      Inst_Valid, 1);
        check("to_inst",       Inst_Out,   0);
        check("to_err",        Fetch_Err,  1);
        check("to_pc",         Inst_Pc,    32'h80);
        tick();

        // Ack on the 16th wait cycle wins over the timeout
        Pc_In = 32'h84; Pc_Valid = 1'b1;
        tick();
        Pc_Valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("late_req", Mem_Req, 1);
        Mem_Ack = 1'b1; Mem_Rdata = 32'hCAFE_F00D;
        tick();
        Mem_Ack = 1'b0;
        check("late_valid", Inst_Valid, 1);
        check("late_err",   Fetch_Err,  0);
        check("late_inst",  Inst_Out,   32'hCAFE_F00D);
        check("late_pc",    Inst_Pc,    32'h84);
        tick();

        // Reset during REQ with a PC buffered
        Pc_In = 32'h88; Pc_Valid = 1'b1;
        tick();
        Pc_In = 32'h8C;
        tick();
        Pc_Valid = 1'b0;
        check("rr_in_req", Mem_Req, 1);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("rr_req",   Mem_Req,    0);
        check("rr_valid", Inst_Valid, 0);
        check("rr_addr",  Mem_Addr,   0);
        tick();
        check("rr_no_pending_launch", Mem_Req, 0);
        Pc_In = 32'h90; Pc_Valid = 1'b1;
        tick();
        Pc_Valid = 1'b0;
        check("rr_req2",  Mem_Req,  1);
        check("rr_addr2", Mem_Addr, 32'h90);
        Mem_Ack = 1'b1; Mem_Rdata = 32'h1234_5678;
        tick();
        Mem_Ack = 1'b0;
        check("rr_inst", Inst_Out,  32'h1234_5678);
        check("rr_pc",   Inst_Pc,   32'h90);
        check("rr_err",  Fetch_Err, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
